hps_instr_queue: RTL and testbench

//  64-bit instruction FIFO between the HPS terminal and the instruction consumer.

---
 rtl/hps_instr_queue.sv | 92 +++++++++
 tb/tb_hps_instr_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hps_instr_queue.sv
// 16 x 64-bit instruction FIFO between the HPS terminal and the instruction consumer.
// Registered read port (1-cycle latency), level/almost-full status and sticky error flags.
module hps_instr_queue #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 64,
  parameter int AF_LEVEL = 12
) (
  input  logic              s_clk,
  input  logic              s_reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_instruction,
  output logic              wr_busy,
  input  logic              rd,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_instruction,
  input  logic              flush,
  output logic [ADDR_W:0]   level,
  output logic              almost_full,
  output logic              err_overflow,
  output logic              err_underflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   LEVEL_FULL = DEPTH;
  localparam logic [ADDR_W:0]   LEVEL_AF   = AF_LEVEL;
  localparam logic [ADDR_W:0]   LEVEL_ONE  = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE    = 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;

  logic full;
  logic empty;
  logic accept;
  logic reject;
  logic serve;
  logic starve;

  // Flush wins over same-cycle wr/rd: neither side moves and no error is recorded.
  always_comb begin
    full   = (count == LEVEL_FULL);
    empty  = (count == '0);
    accept = wr && !full  && !flush && !s_reset;
    reject = wr &&  full  && !flush;
    serve  = rd && !empty && !flush && !s_reset;
    starve = rd &&  empty && !flush;
  end

  assign wr_busy     = full;
  assign almost_full = (count >= LEVEL_AF);
  assign level       = count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge s_clk) begin
    if (s_reset || flush) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (serve)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({accept, serve})
        2'b10:   count <= count + LEVEL_ONE;
        2'b01:   count <= count - LEVEL_ONE;
        default: count <= count;
      endcase
      if (reject) err_overflow  <= 1'b1;
      if (starve) err_underflow <= 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and level define what is valid.
  always_ff @(posedge s_clk) begin
    if (accept) mem[wr_ptr] <= wr_instruction;
  end

  // Flush leaves rd_instruction holding the last served word; only reset clears it.
  always_ff @(posedge s_clk) begin
    if (s_reset) begin
      rd_valid       <= 1'b0;
      rd_instruction <= '0;
    end else begin
      rd_valid <= serve;
      if (serve) rd_instruction <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_hps_instr_queue.sv
// Self-checking bench for hps_instr_queue: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_hps_instr_queue;

  logic        s_clk = 1'b0;
  logic        s_reset = 1'b1;
  logic        wr = 1'b0;
  logic [63:0] wr_instruction = '0;
  logic        wr_busy;
  logic        rd = 1'b0;
  logic        rd_valid;
  logic [63:0] rd_instruction;
  logic        flush = 1'b0;
  logic [4:0]  level;
  logic        almost_full;
  logic        err_overflow;
  logic        err_underflow;

  int checks   = 0;
  int failures = 0;

  hps_instr_queue dut (
    .s_clk          (s_clk),
    .s_reset        (s_reset),
    .wr             (wr),
    .wr_instruction (wr_instruction),
    .wr_busy        (wr_busy),
    .rd             (rd),
    .rd_valid       (rd_valid),
    .rd_instruction (rd_instruction),
    .flush          (flush),
    .level          (level),
    .almost_full    (almost_full),
    .err_overflow   (err_overflow),
    .err_underflow  (err_underflow)
  );

  always #5 s_clk = ~s_clk;

  // Reference model: a plain queue plus the observable output registers.
  logic [63:0] m_q [$];
  logic        m_valid = 1'b0;
  logic [63:0] m_instr = '0;
  logic        m_ovf   = 1'b0;
  logic        m_unf   = 1'b0;

  task automatic model_step(input logic r, w, rr, f, input logic [63:0] d);
    bit was_full, was_empty;
    if (r) begin
      m_q.delete();
      m_valid = 1'b0; m_instr = '0; m_ovf = 1'b0; m_unf = 1'b0;
    end else if (f) begin
      m_q.delete();
      m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      was_full  = (m_q.size() == 16);
      was_empty = (m_q.size() == 0);
      m_valid   = rr && !was_empty;
      if (m_valid) m_instr = m_q.pop_front();
      if (rr && was_empty) m_unf = 1'b1;
      if (w && was_full) m_ovf = 1'b1;
      if (w && !was_full) m_q.push_back(d);
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, advance one edge, and leave outputs settled for sampling.
  task automatic cycle(input logic r, w, rr, f, input logic [63:0] d);
    s_reset = r; wr = w; rd = rr; flush = f; wr_instruction = d;
    model_step(r, w, rr, f, d);
    @(posedge s_clk);
    #1;
    s_reset = 1'b0; wr = 1'b0; rd = 1'b0; flush = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".level"},       64'(level),         64'(m_q.size()));
    check({tag, ".wr_busy"},     64'(wr_busy),       64'(m_q.size() == 16));
    check({tag, ".almost_full"}, 64'(almost_full),   64'(m_q.size() >= 12));
    check({tag, ".rd_valid"},    64'(rd_valid),      64'(m_valid));
    check({tag, ".rd_instr"},    rd_instruction,     m_instr);
    check({tag, ".err_ovf"},     64'(err_overflow),  64'(m_ovf));
    check({tag, ".err_unf"},     64'(err_underflow), 64'(m_unf));
  endtask

  typedef struct {
    logic        rst, w, r, f;
    logic [63:0] data;
    logic [4:0]  e_level;
    logic        e_valid;
    logic [63:0] e_instr;
    logic        e_ovf, e_unf;
  } vec_t;

  function automatic vec_t mk(logic rst, w, r, f, logic [63:0] data, logic [4:0] lv,
                              logic v, logic [63:0] ins, logic ovf, logic unf);
    vec_t t;
    t.rst = rst; t.w = w; t.r = r; t.f = f; t.data = data;
    t.e_level = lv; t.e_valid = v; t.e_instr = ins; t.e_ovf = ovf; t.e_unf = unf;
    return t;
  endfunction

  vec_t vecs [14];

  initial begin
    //             rst   wr    rd    fl    data      level  valid instr    ovf   unf
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 64'h0,    5'd0, 1'b0, 64'h0,   1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 64'h0,    5'd0, 1'b0, 64'h0,   1'b0, 1'b1);
    vecs[2]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 64'hA1,   5'd1, 1'b0, 64'h0,   1'b0, 1'b1);
    vecs[3]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 64'hA2,   5'd2, 1'b0, 64'h0,   1'b0, 1'b1);
    vecs[4]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 64'h0,    5'd1, 1'b1, 64'hA1,  1'b0, 1'b1);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 64'h0,    5'd1, 1'b0, 64'hA1,  1'b0, 1'b1);
    vecs[6]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 64'hA3,   5'd1, 1'b1, 64'hA2,  1'b0, 1'b1);
    vecs[7]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 64'hA4,   5'd0, 1'b0, 64'hA2,  1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 64'h0,    5'd0, 1'b0, 64'hA2,  1'b0, 1'b1);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 64'h0,    5'd0, 1'b0, 64'hA2,  1'b0, 1'b0);
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 64'hA5,   5'd1, 1'b0, 64'hA2,  1'b0, 1'b0);
    vecs[11] = mk(1'b1, 1'b1, 1'b1, 1'b0, 64'hA6,   5'd0, 1'b0, 64'h0,   1'b0, 1'b0);
    vecs[12] = mk(1'b0, 1'b1, 1'b0, 1'b0, 64'hA7,   5'd1, 1'b0, 64'h0,   1'b0, 1'b0);
    vecs[13] = mk(1'b0, 1'b0, 1'b1, 1'b0, 64'h0,    5'd0, 1'b1, 64'hA7,  1'b0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].rst, vecs[i].w, vecs[i].r, vecs[i].f, vecs[i].data);
      check($sformatf("vec%0d.level", i), 64'(level),         64'(vecs[i].e_level));
      check($sformatf("vec%0d.valid", i), 64'(rd_valid),      64'(vecs[i].e_valid));
      check($sformatf("vec%0d.instr", i), rd_instruction,     vecs[i].e_instr);
      check($sformatf("vec%0d.ovf", i),   64'(err_overflow),  64'(vecs[i].e_ovf));
      check($sformatf("vec%0d.unf", i),   64'(err_underflow), 64'(vecs[i].e_unf));
    end

    // Fill to full; almost_full from the 12th write.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'(i));
      check($sformatf("fill%0d.level", i), 64'(level),       64'(i));
      check($sformatf("fill%0d.af", i),    64'(almost_full), 64'(i >= 12));
      check($sformatf("fill%0d.busy", i),  64'(wr_busy),     64'(i == 16));
    end

    // Overflow attempt on a full queue.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'hDEAD);
    check("ovf.level", 64'(level),        64'd16);
    check("ovf.flag",  64'(err_overflow), 64'd1);

    // Drain: each strobe one cycle after its rd, in write order.
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
      check($sformatf("drain%0d.valid", i), 64'(rd_valid),   64'd1);
      check($sformatf("drain%0d.instr", i), rd_instruction,  64'(i));
      check($sformatf("drain%0d.level", i), 64'(level),      64'(16 - i));
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    check("idle.valid", 64'(rd_valid), 64'd0);

    // Empty read, then flush clears both flags.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
    check("empty.valid", 64'(rd_valid),      64'd0);
    check("empty.instr", rd_instruction,     64'h10);
    check("empty.unf",   64'(err_underflow), 64'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
    check("flush.ovf",   64'(err_overflow),  64'd0);
    check("flush.unf",   64'(err_underflow), 64'd0);
    check("flush.instr", rd_instruction,     64'h10);

    // Steady level 5 with wr+rd each cycle, across pointer wrap.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'(100 + i));
    for (int j = 0; j < 20; j++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'(105 + j));
      check($sformatf("steady%0d.level", j), 64'(level),     64'd5);
      check($sformatf("steady%0d.instr", j), rd_instruction, 64'(100 + j));
      check($sformatf("steady%0d.valid", j), 64'(rd_valid),  64'd1);
    end

    // Full plus simultaneous wr+rd: write rejected, read served.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'(200 + i));
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'hBEEF);
    check("fullrw.level", 64'(level),        64'd15);
    check("fullrw.instr", rd_instruction,    64'd200);
    check("fullrw.ovf",   64'(err_overflow), 64'd1);

    // Reset mid-operation with a write pending.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'(300 + i));
    check("pre_rst.level", 64'(level), 64'd9);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 64'h77);
    check("rst.level", 64'(level),    64'd0);
    check("rst.valid", 64'(rd_valid), 64'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'hAB);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
    check("rst_wr.instr", rd_instruction, 64'hAB);
    check("rst_wr.valid", 64'(rd_valid),  64'd1);

    // Randomized traffic against the reference model.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    for (int n = 0; n < 3000; n++) begin
      logic r_w, r_r, r_f, r_rst;
      int   bias;
      bias  = (n / 500) % 2;
      r_w   = ($urandom_range(99) < (bias ? 75 : 40));
      r_r   = ($urandom_range(99) < (bias ? 40 : 75));
      r_f   = ($urandom_range(199) == 0);
      r_rst = ($urandom_range(499) == 0);
      cycle(r_rst, r_w, r_r, r_f, {$urandom, $urandom});
      check_model($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
